// File: rtl/rom_writer.sv
// ---------------------------------------------------------------------------
// rom_writer
//
// Writes a stream of bytes into a parallel EEPROM/flash-style device through a
// multiplexed address bus. The low address byte goes out first and is captured
// by an external latch on the rom_latch_out pulse. The high byte then drives the
// same bus while the data byte is placed on rom_data_out. A rom_we_n_out pulse
// writes the byte. The block then waits out the device's internal write time.
// Addresses run from 0 to TOTAL_ADDRESSES-1, and after the last one the block
// parks in FINISHED until reset.
//
// Every phase length is a whole number of clk_in cycles, ceil(ns / PERIOD_NS) with
// a minimum of 1. One shared down-counter times all of the phases.
//
// Optional feature: define ROM_WRITER_VERIFY_EN to insert a read-back phase after
// each write. In that phase rom_oe_n_out is low for R cycles and rom_data_in is
// compared with the written byte. A mismatch sets error_out, which stays set
// until reset.
//
// Ports
//   clk_in           single clock, rising edge
//   rst_in           asynchronous reset, active-low
//   data_in          byte to program
//   data_valid_in    data_in valid (only looked at while ready_out=1)
//   ready_out        writer accepts a byte on this cycle's rising edge
//   rom_addr_out     multiplexed address bus (low byte, then high byte)
//   rom_latch_out    external address-latch strobe, active-high
//   rom_data_out     write data to the device
//   rom_data_oe_out  tri-state enable for rom_data_out, active-high
//   rom_we_n_out     device write enable, active-low
//   rom_oe_n_out     device output enable, active-low
//   rom_data_in      device data bus read-back
//   finished_out     all TOTAL_ADDRESSES bytes written
//   error_out        sticky read-back mismatch flag
// ---------------------------------------------------------------------------
module rom_writer #(
    parameter int PERIOD_NS       = 10,
    parameter int TOTAL_ADDRESSES = 256,
    parameter int SETUP_NS        = 50,
    parameter int HOLD_NS         = 5,
    parameter int WE_PULSE_NS     = 100,
    parameter int WRITE_CYCLE_NS  = 10000,
    parameter int READ_NS         = 250
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       data_valid_in,
    output logic       ready_out,
    output logic [7:0] rom_addr_out,
    output logic       rom_latch_out,
    output logic [7:0] rom_data_out,
    output logic       rom_data_oe_out,
    output logic       rom_we_n_out,
    output logic       rom_oe_n_out,
    input  logic [7:0] rom_data_in,
    output logic       finished_out,
    output logic       error_out
);

    // State table
    //   state        | meaning
    //   ST_IDLE      | ready_out=1, waiting for data_valid_in
    //   ST_ADDR_LO   | low address byte on bus (S cycles)
    //   ST_LATCH     | rom_latch_out high, low byte held (H cycles)
    //   ST_ADDR_HI   | high address byte on bus, data driven (S cycles)
    //   ST_WE        | rom_we_n_out low (W cycles)
    //   ST_DATA_HOLD | we_n released, data still driven (H cycles)
    //   ST_WAIT      | device internal write time, data bus released (C cycles)
    //   ST_VERIFY    | read-back with rom_oe_n_out low (R cycles, verify build)
    //   ST_FINISHED  | all bytes written, absorbing until reset

    function automatic int ns_to_cycles(input int ns);
        int c;
        c = (ns + PERIOD_NS - 1) / PERIOD_NS;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int S_CYC = ns_to_cycles(SETUP_NS);
    localparam int H_CYC = ns_to_cycles(HOLD_NS);
    localparam int W_CYC = ns_to_cycles(WE_PULSE_NS);
    localparam int C_CYC = ns_to_cycles(WRITE_CYCLE_NS);
    localparam int R_CYC = ns_to_cycles(READ_NS);

    localparam int MAX_CYC = max2(max2(max2(S_CYC, H_CYC), max2(W_CYC, C_CYC)), R_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter is loaded with length-1 on entry to a phase. The phase ends on
    // the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_CYC - 1);
    localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(H_CYC - 1);
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(W_CYC - 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(C_CYC - 1);
`ifdef ROM_WRITER_VERIFY_EN
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(R_CYC - 1);
`endif

    // 17-bit terminal value so that TOTAL_ADDRESSES=65536 is reachable.
    localparam logic [16:0] TOTAL_17 = 17'(TOTAL_ADDRESSES);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_LATCH,
        ST_ADDR_HI,
        ST_WE,
        ST_DATA_HOLD,
        ST_WAIT,
`ifdef ROM_WRITER_VERIFY_EN
        ST_VERIFY,
`endif
        ST_FINISHED
    } state_t;

    state_t           state;
    logic [15:0]      addr;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_q;
    logic [16:0]      addr_next;

    assign addr_next = {1'b0, addr} + 17'd1;

`ifndef ROM_WRITER_VERIFY_EN
    // The read-back bus is only used by the verify build.
    logic unused_rom_data;
    assign unused_rom_data = ^rom_data_in;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_IDLE;
            addr            <= '0;
            cnt             <= '0;
            data_q          <= '0;
            ready_out       <= 1'b0;
            rom_addr_out    <= '0;
            rom_latch_out   <= 1'b0;
            rom_data_out    <= '0;
            rom_data_oe_out <= 1'b0;
            rom_we_n_out    <= 1'b1;
            rom_oe_n_out    <= 1'b1;
            finished_out    <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_valid_in && ready_out) begin
                        data_q       <= data_in;
                        ready_out    <= 1'b0;
                        rom_addr_out <= addr[7:0];
                        cnt          <= S_LOAD;
                        state        <= ST_ADDR_LO;
                    end else begin
                        // ready_out comes up one cycle after reset is released.
                        ready_out <= 1'b1;
                    end
                end

                ST_ADDR_LO: begin
                    if (cnt == '0) begin
                        rom_latch_out <= 1'b1;
                        cnt           <= H_LOAD;
                        state         <= ST_LATCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (cnt == '0) begin
                        rom_latch_out   <= 1'b0;
                        rom_addr_out    <= addr[15:8];
                        rom_data_out    <= data_q;
                        rom_data_oe_out <= 1'b1;
                        cnt             <= S_LOAD;
                        state           <= ST_ADDR_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_ADDR_HI: begin
                    if (cnt == '0) begin
                        rom_we_n_out <= 1'b0;
                        cnt          <= W_LOAD;
                        state        <= ST_WE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_WE: begin
                    if (cnt == '0) begin
                        rom_we_n_out <= 1'b1;
                        cnt          <= H_LOAD;
                        state        <= ST_DATA_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_DATA_HOLD: begin
                    if (cnt == '0) begin
                        rom_data_oe_out <= 1'b0;
                        cnt             <= C_LOAD;
                        state           <= ST_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (cnt == '0) begin
`ifdef ROM_WRITER_VERIFY_EN
                        // The data bus is already released here, so the device
                        // can drive rom_data_in without contention.
                        rom_oe_n_out <= 1'b0;
                        cnt          <= R_LOAD;
                        state        <= ST_VERIFY;
`else
                        addr         <= addr_next[15:0];
                        rom_addr_out <= '0;
                        rom_data_out <= '0;
                        if (addr_next == TOTAL_17) begin
                            finished_out <= 1'b1;
                            state        <= ST_FINISHED;
                        end else begin
                            ready_out <= 1'b1;
                            state     <= ST_IDLE;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

`ifdef ROM_WRITER_VERIFY_EN
                ST_VERIFY: begin
                    if (cnt == '0) begin
                        if (rom_data_in != data_q) begin
                            error_out <= 1'b1;
                        end
                        rom_oe_n_out <= 1'b1;
                        addr         <= addr_next[15:0];
                        rom_addr_out <= '0;
                        rom_data_out <= '0;
                        if (addr_next == TOTAL_17) begin
                            finished_out <= 1'b1;
                            state        <= ST_FINISHED;
                        end else begin
                            ready_out <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif

                ST_FINISHED: begin
                    ready_out <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_writer.sv
// ---------------------------------------------------------------------------
// tb_rom_writer
//
// Three instances of rom_writer:
//   u_a  default parameters; directed 0xA5 write timing at full-size delays
//   u_b  short delays, TOTAL_ADDRESSES=260; random stream against a timeline
//        model, reset mid-WE, and the run to FINISHED
//   u_c  short delays, TOTAL_ADDRESSES=4; data_valid_in held high throughout
// The bench follows ROM_WRITER_VERIFY_EN in the same way the design does.
// ---------------------------------------------------------------------------
module tb_rom_writer;

`ifdef ROM_WRITER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // Phase lengths of u_b/u_c: ceil(20/10)=2, ceil(5/10)=1, ceil(30/10)=3,
    // ceil(45/10)=5, ceil(25/10)=3
    localparam int S = 2;
    localparam int H = 1;
    localparam int W = 3;
    localparam int C = 5;
    localparam int R = 3;
    localparam int SEQ     = 2*S + 2*H + W + C + (VERIFY ? R : 0);
    localparam int B_TOTAL = 260;
    // Default parameters: 2*5 + 2*1 + 10 + 1000 (+25 with read-back)
    localparam int A_READY = 1022 + (VERIFY ? 25 : 0);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A (defaults) ----------------
    logic       rst_a = 1'b1;
    logic [7:0] din_a = 8'h00;
    logic       dv_a  = 1'b0;
    logic [7:0] cur_a = 8'h00;
    logic       ready_a, latch_a, doe_a, we_n_a, oe_n_a, fin_a, err_a;
    logic [7:0] addr_a, data_a, rdin_a;
    assign rdin_a = (cur_a == 8'hA5) ? 8'h5A : cur_a;

    rom_writer u_a (
        .clk_in(clk), .rst_in(rst_a), .data_in(din_a), .data_valid_in(dv_a),
        .ready_out(ready_a), .rom_addr_out(addr_a), .rom_latch_out(latch_a),
        .rom_data_out(data_a), .rom_data_oe_out(doe_a), .rom_we_n_out(we_n_a),
        .rom_oe_n_out(oe_n_a), .rom_data_in(rdin_a), .finished_out(fin_a),
        .error_out(err_a)
    );

    // ---------------- instance B (model-checked) ----------------
    logic       rst_b = 1'b1;
    logic [7:0] din_b = 8'h00;
    logic       dv_b  = 1'b0;
    logic       ready_b, latch_b, doe_b, we_n_b, oe_n_b, fin_b, err_b;
    logic [7:0] addr_b, data_b, rdin_b;

    rom_writer #(
        .PERIOD_NS(10), .TOTAL_ADDRESSES(B_TOTAL), .SETUP_NS(20), .HOLD_NS(5),
        .WE_PULSE_NS(30), .WRITE_CYCLE_NS(45), .READ_NS(25)
    ) u_b (
        .clk_in(clk), .rst_in(rst_b), .data_in(din_b), .data_valid_in(dv_b),
        .ready_out(ready_b), .rom_addr_out(addr_b), .rom_latch_out(latch_b),
        .rom_data_out(data_b), .rom_data_oe_out(doe_b), .rom_we_n_out(we_n_b),
        .rom_oe_n_out(oe_n_b), .rom_data_in(rdin_b), .finished_out(fin_b),
        .error_out(err_b)
    );

    // ---------------- instance C (TOTAL=4, valid held) ----------------
    logic       dv_c = 1'b0;
    logic [7:0] din_c = 8'h11;
    logic       ready_c, latch_c, doe_c, we_n_c, oe_n_c, fin_c, err_c;
    logic [7:0] addr_c, data_c;

    rom_writer #(
        .PERIOD_NS(10), .TOTAL_ADDRESSES(4), .SETUP_NS(20), .HOLD_NS(5),
        .WE_PULSE_NS(30), .WRITE_CYCLE_NS(45), .READ_NS(25)
    ) u_c (
        .clk_in(clk), .rst_in(rst_a), .data_in(din_c), .data_valid_in(dv_c),
        .ready_out(ready_c), .rom_addr_out(addr_c), .rom_latch_out(latch_c),
        .rom_data_out(data_c), .rom_data_oe_out(doe_c), .rom_we_n_out(we_n_c),
        .rom_oe_n_out(oe_n_c), .rom_data_in(data_c), .finished_out(fin_c),
        .error_out(err_c)
    );

    int acc_c = 0;
    int bad_c = 0;
    always @(negedge clk) begin
        if (rst_a && ready_c && dv_c) acc_c++;
        if (rst_a && fin_c && (!we_n_c || !oe_n_c || latch_c || doe_c || ready_c)) bad_c++;
    end

    // ---------------- B reference model: one write is a fixed timeline ----------------
    // m_t counts clock edges since the accepting edge. The write ends at m_t == SEQ.
    bit          m_busy, m_ready, m_fin, m_err;
    int          m_t;
    int          m_accepts;
    logic [16:0] m_addr;
    logic [7:0]  m_data;
    assign rdin_b = (m_data == 8'hA5) ? 8'h5A : m_data;

    always @(posedge clk) begin
        if (!rst_b) begin
            m_busy = 0; m_ready = 0; m_fin = 0; m_err = 0;
            m_t = 0; m_accepts = 0; m_addr = '0; m_data = 8'h00;
        end else if (m_busy) begin
            m_t++;
            if (m_t == SEQ) begin
                if (VERIFY && m_data == 8'hA5) m_err = 1;
                m_busy = 0;
                m_addr = m_addr + 17'd1;
                if (m_addr == 17'(B_TOTAL)) m_fin = 1;
                else m_ready = 1;
            end
        end else if (!m_fin) begin
            if (m_ready && dv_b) begin
                m_busy = 1; m_t = 0; m_data = din_b; m_ready = 0; m_accepts++;
            end else begin
                m_ready = 1;
            end
        end
    end

    bit          cmp_en = 0;
    bit          in_lo, in_latch, in_dat, in_we, in_ver;
    logic [22:0] exp_v, act_v, mask_v;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!rst_b) begin
                exp_v  = {7'b0001100, 8'h00, 8'h00};
                mask_v = '1;
            end else begin
                in_lo    = m_busy && (m_t < S + H);
                in_latch = m_busy && (m_t >= S) && (m_t < S + H);
                in_dat   = m_busy && (m_t >= S + H) && (m_t < 2*S + 2*H + W);
                in_we    = m_busy && (m_t >= 2*S + H) && (m_t < 2*S + H + W);
                in_ver   = m_busy && (m_t >= 2*S + 2*H + W + C) && (m_t < SEQ);
                exp_v  = {m_ready, m_fin, m_err, !in_we, !in_ver, in_latch, in_dat,
                          in_lo ? m_addr[7:0] : m_addr[15:8], m_data};
                mask_v = {7'h7f, (in_lo || in_dat || in_ver) ? 8'hff : 8'h00,
                          in_dat ? 8'hff : 8'h00};
            end
            act_v = {ready_b, fin_b, err_b, we_n_b, oe_n_b, latch_b, doe_b, addr_b, data_b};
            checks++;
            if (((act_v ^ exp_v) & mask_v) !== 23'd0) begin
                errors++;
                $display("FAIL b_cycle at %0t actual=%06h required=%06h mask=%06h",
                         $time, act_v, exp_v, mask_v);
            end
            checks++;
            if ((!we_n_b && !oe_n_b) || (!oe_n_b && doe_b)) begin
                errors++;
                $display("FAIL b_bus_conflict at %0t we_n=%b oe_n=%b doe=%b required no overlap",
                         $time, we_n_b, oe_n_b, doe_b);
            end
        end
    end

    // Records the low and high address bytes the external latch and device see,
    // one entry per byte written since the last reset.
    logic [7:0] lo_rec [512];
    logic [7:0] hi_rec [512];
    int         nb = 0;
    bit         p_latch = 0, p_doe = 0;
    always @(negedge clk) begin
        if (!rst_b) begin
            nb = 0; p_latch = 0; p_doe = 0;
        end else begin
            if (latch_b && !p_latch && nb < 512) lo_rec[nb] = addr_b;
            if (doe_b && !p_doe && nb < 512) begin
                hi_rec[nb] = addr_b;
                nb++;
            end
            p_latch = latch_b;
            p_doe   = doe_b;
        end
    end

    task automatic a_write(input logic [7:0] b, output int latch_t, output logic [7:0] lo,
                           output logic [7:0] hi, output logic [7:0] dat, output int we_cnt,
                           output int oe_cnt, output int ready_t);
        latch_t = -1; ready_t = -1; we_cnt = 0; oe_cnt = 0;
        lo = 8'h00; hi = 8'h00; dat = 8'h00;
        cur_a = b;
        for (int i = 0; i < 20 && !ready_a; i++) @(negedge clk);
        #2;
        dv_a = 1'b1; din_a = b;
        @(posedge clk);
        #1;
        dv_a = 1'b0;
        for (int t = 0; t < A_READY + 4; t++) begin
            @(negedge clk);
            if (latch_a && latch_t < 0) begin latch_t = t; lo = addr_a; end
            if (!we_n_a) begin we_cnt++; hi = addr_a; dat = data_a; end
            if (!oe_n_a) oe_cnt++;
            if (ready_a && ready_t < 0) ready_t = t;
        end
    endtask

    initial begin
        int latch_t, we_cnt, oe_cnt, ready_t;
        logic [7:0] lo, hi, dat;
        bit found;

        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        cmp_en = 1;
        repeat (2) @(negedge clk);

        // ---- A: reset state ----
        check("a_rst_ready", ready_a, 0);
        check("a_rst_we_n", we_n_a, 1);
        check("a_rst_oe_n", oe_n_a, 1);
        check("a_rst_bus", {latch_a, doe_a, addr_a, data_a, fin_a, err_a}, 0);
        #2;
        rst_a = 1'b0;
        rst_a = 1'b1;
        dv_c  = 1'b1;

        // ---- A: 0xA5 at default timing ----
        a_write(8'hA5, latch_t, lo, hi, dat, we_cnt, oe_cnt, ready_t);
        check("a_latch_cycle", latch_t, 5);
        check("a_latch_addr", lo, 8'h00);
        check("a_hi_addr", hi, 8'h00);
        check("a_we_data", dat, 8'hA5);
        check("a_we_low_cycles", we_cnt, 10);
        check("a_oe_low_cycles", oe_cnt, VERIFY ? 25 : 0);
        check("a_ready_latency", ready_t, A_READY);
        check("a_error_after_a5", err_a, VERIFY);

        // Second byte goes to address 1; the error flag stays sticky.
        a_write(8'h3C, latch_t, lo, hi, dat, we_cnt, oe_cnt, ready_t);
        check("a2_latch_addr", lo, 8'h01);
        check("a2_we_data", dat, 8'h3C);
        check("a2_ready_latency", ready_t, A_READY);
        check("a2_error_sticky", err_a, VERIFY);

        // ---- C: TOTAL_ADDRESSES=4 with data_valid_in held ----
        check("c_accepts", acc_c, 4);
        check("c_finished", fin_c, 1);
        check("c_bus_after_finish", bad_c, 0);
        check("c_error", err_c, 0);

        // ---- B: random stream, reset mid-WE, run to FINISHED ----
        @(negedge clk);
        #2;
        rst_b = 1'b1;
        for (int i = 0; i < 2000 && m_accepts < 20; i++) begin
            @(negedge clk);
            #2;
            dv_b  = ($urandom_range(0, 3) != 0);
            din_b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        end
        check("b_first_phase_accepts", (m_accepts >= 20), 1);

        dv_b = 1'b1;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_busy && m_t >= 2*S + H && m_t < 2*S + H + W) begin
                found = 1;
                break;
            end
        end
        check("b_we_window_found", found, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("b_rst_we_n_async", we_n_b, 1);
        check("b_rst_doe_async", doe_b, 0);
        check("b_rst_latch_async", latch_b, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_b = 1'b1;

        for (int i = 0; i < 20000 && !m_fin; i++) begin
            @(negedge clk);
            #2;
            dv_b  = ($urandom_range(0, 3) != 0);
            din_b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        end
        dv_b = 1'b1;
        repeat (40) @(negedge clk);

        check("b_finished", fin_b, 1);
        check("b_ready_finished", ready_b, 0);
        check("b_bytes_written", nb, B_TOTAL);
        if (nb >= B_TOTAL) begin
            check("b_lo_0", lo_rec[0], 8'h00);
            check("b_hi_0", hi_rec[0], 8'h00);
            check("b_lo_37", lo_rec[37], 8'h25);
            check("b_lo_256", lo_rec[256], 8'h00);
            check("b_hi_256", hi_rec[256], 8'h01);
            check("b_lo_259", lo_rec[259], 8'h03);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
